// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK          = 8'hF0;
  localparam int         PS2_DATA_BITS      = 8;
  localparam int         PS2_FILTER_LEN_DEF = 8;
  localparam int         PS2_TIMEOUT_DEF    = 50_000;

  // 1 when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data_b, input logic par_b);
    return ^{data_b, par_b};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes ps2_clk/ps2_data, glitch-filters the clock and emits a one-cycle
// strobe on each filtered falling edge together with the data sampled at that edge.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q;
  logic          data_q;

  // cnt_q counts consecutive samples that disagree with the filtered level;
  // the FILTER_LEN-th such sample flips the level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= filt_q & ~filt_d;
      data_q      <= data_sync_q[1];
    end
  end

  assign fall_o = fall_q;
  assign data_o = data_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver: assembles 11-bit frames into bytes and
// keeps the last two accepted bytes on keycode.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        read_complete,
  output logic        frame_err
);

  // state  | meaning
  // IDLE   | waiting for a start bit (edge with data=0)
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | next edge carries the parity bit
  // STOP   | next edge carries the stop bit; frame judged here

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic          fall;
  logic          data;
  ps2_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [15:0]   keycode_q;
  logic          rc_q;
  logic          fe_q;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst_b     (rst_b),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .fall_o    (fall),
    .data_o    (data)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      keycode_q <= '0;
      rc_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rc_q <= 1'b0;
      fe_q <= 1'b0;

      if (state_q == IDLE || fall) tmo_q <= '0;
      else                         tmo_q <= tmo_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (fall && !data) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shift_q   <= {data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
              state_q   <= PARITY;
              bit_cnt_q <= '0;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par_q   <= data;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_q <= IDLE;
            if (data && ps2_parity_ok(shift_q, par_q)) begin
              keycode_q <= {keycode_q[7:0], shift_q};
              rc_q      <= 1'b1;
            end else begin
              fe_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Abort a stalled partial frame; the device stopped clocking mid-frame.
      if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        tmo_q     <= '0;
        fe_q      <= 1'b1;
      end
    end
  end

  assign keycode       = keycode_q;
  assign read_complete = rc_q;
  assign frame_err     = fe_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed frames plus random traffic
// compared every cycle against an expected-frame queue model.
module tb_ps2_keycode_rx;

  localparam int FL  = 8;
  localparam int TMO = 50_000;
  localparam int H   = 20;

  logic        clk      = 1'b0;
  logic        rst_b    = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        read_complete;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int rc_cnt = 0;
  int fe_cnt = 0;

  // Each entry: {frame_is_valid, byte}; pushed when the stop-bit edge is driven.
  logic [8:0]  exp_q[$];
  logic [15:0] model_kc = 16'h0000;

  always #10 clk = ~clk;

  ps2_keycode_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .keycode      (keycode),
    .read_complete(read_complete),
    .frame_err    (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_b) begin
      model_kc = 16'h0000;
      exp_q.delete();
      chk("reset_outputs", {14'b0, keycode, read_complete, frame_err}, 32'h0);
    end else begin
      chk("pulse_exclusive", {31'b0, read_complete & frame_err}, 32'h0);
      if (read_complete || frame_err) begin
        if (read_complete) rc_cnt++;
        if (frame_err)     fe_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual rc=%0b fe=%0b required none", read_complete, frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_rc", {31'b0, read_complete}, {31'b0, e[8]});
          if (e[8]) model_kc = {model_kc[7:0], e[7:0]};
        end
      end
      chk("keycode", {16'b0, keycode}, {16'b0, model_kc});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drives the first nbits of {stop, par, byte, start}; a full 11-bit frame
  // registers its expected outcome at the stop-bit falling edge.
  task automatic send(input logic [7:0] b, input logic par, input logic stop,
                      input int nbits, input bit glitch, input logic start);
    logic [10:0] f;
    f = {stop, par, b, start};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch && i > 0) begin
        cycles(5);
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(H - 8);
      end else begin
        cycles(H);
      end
      ps2_clk = 1'b0;
      if (i == 10) exp_q.push_back({stop & (^{b, par}), b});
      cycles(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input bit glitch);
    send(b, ~(^b), 1'b1, 11, glitch, 1'b0);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("pulse_within_bound", exp_q.size(), 32'd0);
    exp_q.delete();
    cycles(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0, fe0, r;
    logic [7:0] b;

    cycles(5);
    chk("rst_keycode", {16'b0, keycode}, 32'h0);
    rst_b = 1'b1;
    cycles(5);

    // Single valid frame.
    rc0 = rc_cnt; fe0 = fe_cnt;
    send_good(8'h1D, 1'b0);
    drain(40);
    chk("f1d_keycode", {16'b0, keycode}, 32'h001D);
    chk("f1d_model", {16'b0, model_kc}, 32'h001D);
    chk("f1d_rc", rc_cnt - rc0, 1);
    chk("f1d_fe", fe_cnt - fe0, 0);

    // Break prefix followed by a make code.
    rc0 = rc_cnt;
    send_good(8'hF0, 1'b0);
    drain(40);
    chk("brk_keycode1", {16'b0, keycode}, 32'h1DF0);
    send_good(8'h1D, 1'b0);
    drain(40);
    chk("brk_keycode2", {16'b0, keycode}, 32'hF01D);
    chk("brk_model", {16'b0, model_kc}, 32'hF01D);
    chk("brk_rc", rc_cnt - rc0, 2);

    // Wrong parity.
    rc0 = rc_cnt; fe0 = fe_cnt;
    send(8'h1B, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    drain(40);
    chk("par_keycode", {16'b0, keycode}, 32'hF01D);
    chk("par_fe", fe_cnt - fe0, 1);
    chk("par_rc", rc_cnt - rc0, 0);

    // Lone edge with data high while idle: no frame, no pulse.
    rc0 = rc_cnt; fe0 = fe_cnt;
    send(8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    cycles(60);
    chk("idle_edge_pulses", (rc_cnt - rc0) + (fe_cnt - fe0), 0);

    // Stalled partial frame: start + 5 data bits, then no clock.
    fe0 = fe_cnt;
    send(8'h15, 1'b0, 1'b0, 6, 1'b0, 1'b0);
    cycles(TMO - 50);
    chk("tmo_not_early", fe_cnt - fe0, 0);
    exp_q.push_back(9'h000);
    drain(300);
    chk("tmo_fe", fe_cnt - fe0, 1);
    send_good(8'h42, 1'b0);
    drain(40);
    chk("tmo_next_low", {24'b0, keycode[7:0]}, 32'h42);

    // Short low glitches between bits.
    send_good(8'h43, 1'b1);
    drain(40);
    chk("glitch_low", {24'b0, keycode[7:0]}, 32'h43);

    // Reset in the middle of a frame.
    rc0 = rc_cnt; fe0 = fe_cnt;
    send(8'h0A, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    rst_b    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cycles(10);
    chk("rst_mid_pulses", (rc_cnt - rc0) + (fe_cnt - fe0), 0);
    rst_b = 1'b1;
    cycles(5);
    send_good(8'h1D, 1'b0);
    drain(40);
    chk("rst_mid_keycode", {16'b0, keycode}, 32'h001D);

    // Random traffic against the queue model.
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       send_good(b, 1'($urandom));
      else if (r == 7) send(b, ^b, 1'b1, 11, 1'b0, 1'b0);
      else if (r == 8) send(b, ~(^b), 1'b0, 11, 1'($urandom), 1'b0);
      else             send(b, 1'b0, 1'b0, 1, 1'b0, 1'b1);
      drain(60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
